// File: rtl/spad_mb.sv
// Multi-bank scratchpad: NUM_BANKS word-interleaved single-port banks, with one
// write port and one read port. Same-bank collisions are arbitrated by alternating priority.

module RAM_SP #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int Implementation = 0
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // data_o is registered and holds its value between reads.
  generate
    if (Implementation == 0) begin : g_generic
      always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= data_i;
        else if (re_i) data_o <= mem_q[addr_i];
      end
    end else begin : g_macro
      // Technology macros replace this branch.
      // Its behaviour matches the generic model.
      always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= data_i;
        else if (re_i) data_o <= mem_q[addr_i];
      end
    end
  endgenerate

endmodule

module spad_mb #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int NUM_BANKS      = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int Implementation = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_data_valid_o,
  input  logic                  clr_cnt_i,
  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  // Handshake: a port transfers on a rising edge where valid and ready are both high.
  // The ready signals depend only on the two valids, the two bank selects and prio_q.
  // They never depend on any ready, so upstream logic cannot form a loop.

  localparam int SEL_W     = $clog2(NUM_BANKS);
  localparam int BANK_BITS = (SEL_W > 0) ? SEL_W : 1;
  localparam int LOCAL_AW  = ADDR_WIDTH - SEL_W;

  logic [BANK_BITS-1:0]  wr_bank, rd_bank, rd_bank_q;
  logic [LOCAL_AW-1:0]   wr_local, rd_local;
  logic [DATA_WIDTH-1:0] bank_dout [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_we, bank_re;
  logic                  conflict, wr_fire, rd_fire;
  logic                  prio_q;

  generate
    if (SEL_W == 0) begin : g_one_bank
      assign wr_bank   = '0;
      assign rd_bank   = '0;
      assign wr_local  = wr_addr_i;
      assign rd_local  = rd_addr_i;
      assign rd_data_o = bank_dout[0];
    end else begin : g_multi_bank
      assign wr_bank   = wr_addr_i[SEL_W-1:0];
      assign rd_bank   = rd_addr_i[SEL_W-1:0];
      assign wr_local  = wr_addr_i[ADDR_WIDTH-1:SEL_W];
      assign rd_local  = rd_addr_i[ADDR_WIDTH-1:SEL_W];
      assign rd_data_o = bank_dout[rd_bank_q];
    end
  endgenerate

  // prio_q = 0 lets the read win a collision; prio_q = 1 lets the write win.
  assign conflict   = wr_valid_i && rd_valid_i && (wr_bank == rd_bank);
  assign wr_ready_o = !conflict || prio_q;
  assign rd_ready_o = !conflict || !prio_q;
  assign wr_fire    = wr_valid_i && wr_ready_o && !rst_i;
  assign rd_fire    = rd_valid_i && rd_ready_o && !rst_i;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign bank_we[b] = wr_fire && (wr_bank == BANK_BITS'(b));
      assign bank_re[b] = rd_fire && (rd_bank == BANK_BITS'(b));

      RAM_SP #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (LOCAL_AW),
        .Implementation (Implementation)
      ) u_bank (
        .clk_i  (clk_i),
        .we_i   (bank_we[b]),
        .re_i   (bank_re[b]),
        .addr_i (bank_we[b] ? wr_local : rd_local),
        .data_i (wr_data_i),
        .data_o (bank_dout[b])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q          <= 1'b0;
      rd_bank_q       <= '0;
      rd_data_valid_o <= 1'b0;
      conflict_cnt_o  <= '0;
    end else begin
      rd_data_valid_o <= rd_fire;
      if (rd_fire) rd_bank_q <= rd_bank;
      // On a collision, pass priority to the losing port so it wins the next one.
      if (conflict) prio_q <= !prio_q;
      if (clr_cnt_i) conflict_cnt_o <= '0;
      else if (conflict && (conflict_cnt_o != '1)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_spad_mb.sv
// Directed bench for spad_mb. Two instances share all inputs: one has a 16-bit
// conflict counter and one has a 2-bit counter, so saturation is exercised.

module tb_spad_mb;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0, rd_valid = 1'b0, clr_cnt = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic          wr_ready_a, rd_ready_a, rd_dv_a;
  logic          wr_ready_b, rd_ready_b, rd_dv_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [15:0]   cnt_a;
  logic [1:0]    cnt_b;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  logic          exp_dv = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  // clock/reset block
  always #5 clk = ~clk;

  spad_mb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(2), .CNT_WIDTH(16), .Implementation(0)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_a), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_a), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_a), .rd_data_valid_o(rd_dv_a),
    .clr_cnt_i(clr_cnt), .conflict_cnt_o(cnt_a)
  );

  spad_mb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(2), .CNT_WIDTH(2), .Implementation(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_b), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_b), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data_b), .rd_data_valid_o(rd_dv_b),
    .clr_cnt_i(clr_cnt), .conflict_cnt_o(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of requests.
  // ew, er and ecnt give the expected readies and counter value for this cycle.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic clr,
                      input logic ew, input logic er, input int ecnt);
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; clr_cnt = clr;
    @(negedge clk);
    check("wr_ready_a", wr_ready_a, ew);
    check("rd_ready_a", rd_ready_a, er);
    check("wr_ready_b", wr_ready_b, ew);
    check("rd_ready_b", rd_ready_b, er);
    check("cnt_a", cnt_a, ecnt);
    check("cnt_b_sat", cnt_b, (ecnt > 3) ? 3 : ecnt);
    if (rv && er) exp_q.push_back(mem_m[ra]);
    if (wv && ew) mem_m[wa] = wd;
    @(posedge clk);
    #1;
    exp_dv = rv && er;
  endtask

  // Monitor / scoreboard: checks the read-return pulse each cycle and pops expected data.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    check("rd_valid_a", rd_dv_a, exp_dv);
    check("rd_valid_b", rd_dv_b, exp_dv);
    if (exp_dv && rd_dv_a) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_underflow: got read data %0h, expected no pending read", rd_data_a);
      end else begin
        e = exp_q.pop_front();
        check("rd_data_a", rd_data_a, e);
        check("rd_data_b", rd_data_b, e);
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset, then different-bank parallel access
    step(0, 0,  8'h00, 0, 0,  0, 1, 1, 0);
    step(1, 5,  8'h5A, 0, 0,  0, 1, 1, 0);
    step(1, 6,  8'h66, 0, 0,  0, 1, 1, 0);
    step(1, 4,  8'hA5, 1, 5,  0, 1, 1, 0);
    step(0, 0,  8'h00, 1, 4,  0, 1, 1, 0);

    // single conflict: read wins first, then the held write goes through
    step(1, 2,  8'h3C, 1, 6,  0, 0, 1, 0);
    step(1, 2,  8'h3C, 0, 0,  0, 1, 1, 1);

    // sustained bank-0 conflict; the loser holds its request stable
    step(1, 10, 8'h10, 1, 10, 0, 1, 0, 1);
    step(1, 10, 8'h11, 1, 10, 0, 0, 1, 2);
    step(1, 10, 8'h11, 1, 10, 0, 1, 0, 3);
    step(1, 10, 8'h12, 1, 10, 0, 0, 1, 4);
    step(1, 10, 8'h12, 1, 10, 0, 1, 0, 5);
    step(1, 10, 8'h13, 1, 10, 0, 0, 1, 6);
    step(1, 10, 8'h13, 0, 0,  0, 1, 1, 7);

    // counter clear, and clear during a conflict cycle
    step(0, 0,  8'h00, 0, 0,  1, 1, 1, 7);
    step(1, 12, 8'h77, 1, 10, 1, 1, 0, 0);
    step(1, 14, 8'h88, 1, 10, 0, 0, 1, 0);
    step(1, 14, 8'h88, 0, 0,  0, 1, 1, 1);
    step(0, 0,  8'h00, 1, 12, 0, 1, 1, 1);
    step(0, 0,  8'h00, 1, 14, 0, 1, 1, 1);

    // reset right after a read is accepted; a write during reset must be ignored
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4; clr_cnt = 1'b0;
    @(negedge clk);
    check("rd_ready_pre_rst", rd_ready_a, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1; rd_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 4; wr_data = 8'hEE;
    exp_dv = 1'b0;
    @(negedge clk);
    check("cnt_a_rst", cnt_a, 0);
    check("cnt_b_rst", cnt_b, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // contents survive reset, and priority is back to read-first
    step(0, 0,  8'h00, 1, 4,  0, 1, 1, 0);
    step(1, 6,  8'h99, 1, 4,  0, 0, 1, 0);
    step(1, 6,  8'h99, 0, 0,  0, 1, 1, 1);
    step(0, 0,  8'h00, 1, 6,  0, 1, 1, 1);
    step(0, 0,  8'h00, 1, 2,  0, 1, 1, 1);
    step(0, 0,  8'h00, 0, 0,  0, 1, 1, 1);
    step(0, 0,  8'h00, 0, 0,  0, 1, 1, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
